// File: rtl/settings_bus_pkg.sv
// Shared types and constants for the settings-bus command bridge: FSM states,
// command-word field positions and response status codes.
package settings_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WAIT_RB = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Command word layout (64 bits); bits [63:49] carry nothing.
  localparam int CMD_SET_DATA_LSB = 0;
  localparam int CMD_SET_ADDR_LSB = 32;
  localparam int CMD_RB_ADDR_LSB  = 40;
  localparam int CMD_WANT_RB_BIT  = 48;

  // Response status codes carried on resp_tuser.
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  localparam logic [15:0] TIMEOUT_CNT_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == TIMEOUT_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/settings_bus_timeout_ctr.sv
// Readback wait counter: held at zero while clear is high, counts up while
// enabled, and flags expired once it sits at TIMEOUT-1 (it parks there).
module settings_bus_timeout_ctr
  import settings_bus_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Cycle counter; clear dominates enable so each wait starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/settings_bus_cmd_bridge.sv
// Settings-bus master: turns 64-bit command words into one-cycle settings
// writes, optionally waits (bounded) for the slave's readback strobe and returns
// the data with a status code on a response stream. One transaction in flight.
module settings_bus_cmd_bridge
  import settings_bus_pkg::*;
#(
  parameter int SR_AWIDTH = 8,
  parameter int SR_DWIDTH = 32,
  parameter int RB_AWIDTH = 8,
  parameter int RB_DWIDTH = 64,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [63:0]          cmd_tdata,
  input  logic                 cmd_tvalid,
  output logic                 cmd_tready,
  output logic [RB_DWIDTH-1:0] resp_tdata,
  output logic [1:0]           resp_tuser,
  output logic                 resp_tvalid,
  input  logic                 resp_tready,
  output logic                 set_stb,
  output logic [SR_AWIDTH-1:0] set_addr,
  output logic [SR_DWIDTH-1:0] set_data,
  output logic [RB_AWIDTH-1:0] rb_addr,
  input  logic                 rb_stb,
  input  logic [RB_DWIDTH-1:0] rb_data,
  output logic                 busy,
  output logic [15:0]          timeout_cnt
);

  if (SR_DWIDTH != 32) begin : g_bad_sr_dwidth
    $error("settings_bus_cmd_bridge: SR_DWIDTH must be 32");
  end
  if ((SR_AWIDTH < 1) || (SR_AWIDTH > 8)) begin : g_bad_sr_awidth
    $error("settings_bus_cmd_bridge: SR_AWIDTH must be 1..8");
  end
  if ((RB_AWIDTH < 1) || (RB_AWIDTH > 8)) begin : g_bad_rb_awidth
    $error("settings_bus_cmd_bridge: RB_AWIDTH must be 1..8");
  end
  if ((RB_DWIDTH < 1) || (RB_DWIDTH > 64)) begin : g_bad_rb_dwidth
    $error("settings_bus_cmd_bridge: RB_DWIDTH must be 1..64");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("settings_bus_cmd_bridge: TIMEOUT must be >= 1");
  end

  // Current registered state and the values every output takes next cycle.
  state_e                 state_r,       state_s;
  logic                   cmd_tready_r,  cmd_tready_s;
  logic                   set_stb_r,     set_stb_s;
  logic [SR_AWIDTH-1:0]   set_addr_r,    set_addr_s;
  logic [SR_DWIDTH-1:0]   set_data_r,    set_data_s;
  logic [RB_AWIDTH-1:0]   rb_addr_r,     rb_addr_s;
  logic                   want_rb_r,     want_rb_s;
  logic                   resp_tvalid_r, resp_tvalid_s;
  logic [RB_DWIDTH-1:0]   resp_tdata_r,  resp_tdata_s;
  logic [1:0]             resp_tuser_r,  resp_tuser_s;
  logic                   busy_r,        busy_s;
  logic [15:0]            timeout_cnt_r, timeout_cnt_s;

  // Command fields; address bits above the configured widths are dropped here.
  logic [SR_AWIDTH-1:0] cmd_set_addr_s;
  logic [SR_DWIDTH-1:0] cmd_set_data_s;
  logic [RB_AWIDTH-1:0] cmd_rb_addr_s;
  logic                 cmd_want_rb_s;
  logic                 unused_cmd_bits_s;

  assign cmd_set_addr_s    = cmd_tdata[CMD_SET_ADDR_LSB +: SR_AWIDTH];
  assign cmd_set_data_s    = cmd_tdata[CMD_SET_DATA_LSB +: SR_DWIDTH];
  assign cmd_rb_addr_s     = cmd_tdata[CMD_RB_ADDR_LSB +: RB_AWIDTH];
  assign cmd_want_rb_s     = cmd_tdata[CMD_WANT_RB_BIT];
  assign unused_cmd_bits_s = ^cmd_tdata;

  logic ctr_clear_s;
  logic ctr_enable_s;
  logic ctr_expired_s;

  // The wait counter only runs in WAIT_RB and is zero on every entry.
  assign ctr_clear_s  = (state_r != WAIT_RB);
  assign ctr_enable_s = (state_r == WAIT_RB);

  settings_bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear   (ctr_clear_s),
    .enable  (ctr_enable_s),
    .expired (ctr_expired_s)
  );

  // Next-state and next-output logic; outputs hold unless a transition moves them.
  always_comb begin
    state_s       = state_r;
    set_stb_s     = 1'b0;
    set_addr_s    = '0;
    set_data_s    = '0;
    rb_addr_s     = rb_addr_r;
    want_rb_s     = want_rb_r;
    resp_tvalid_s = resp_tvalid_r;
    resp_tdata_s  = resp_tdata_r;
    resp_tuser_s  = resp_tuser_r;
    timeout_cnt_s = timeout_cnt_r;

    case (state_r)
      IDLE: begin
        if (cmd_tvalid && cmd_tready_r) begin
          state_s    = STROBE;
          set_stb_s  = 1'b1;
          set_addr_s = cmd_set_addr_s;
          set_data_s = cmd_set_data_s;
          rb_addr_s  = cmd_rb_addr_s;
          want_rb_s  = cmd_want_rb_s;
        end else begin
          state_s = IDLE;
        end
      end

      STROBE: begin
        // A slave answering in the strobe cycle itself is captured here.
        if (want_rb_r) begin
          if (rb_stb) begin
            state_s       = RESP;
            resp_tvalid_s = 1'b1;
            resp_tdata_s  = rb_data;
            resp_tuser_s  = ST_OK;
          end else begin
            state_s = WAIT_RB;
          end
        end else begin
          state_s   = IDLE;
          rb_addr_s = '0;
        end
      end

      WAIT_RB: begin
        // A strobe in the final counted cycle still beats the timeout.
        if (rb_stb) begin
          state_s       = RESP;
          resp_tvalid_s = 1'b1;
          resp_tdata_s  = rb_data;
          resp_tuser_s  = ST_OK;
        end else if (ctr_expired_s) begin
          state_s       = RESP;
          resp_tvalid_s = 1'b1;
          resp_tdata_s  = '0;
          resp_tuser_s  = ST_TIMEOUT;
          timeout_cnt_s = sat_inc16(timeout_cnt_r);
        end else begin
          state_s = WAIT_RB;
        end
      end

      RESP: begin
        if (resp_tready) begin
          state_s       = IDLE;
          resp_tvalid_s = 1'b0;
          resp_tdata_s  = '0;
          resp_tuser_s  = ST_OK;
          rb_addr_s     = '0;
          want_rb_s     = 1'b0;
        end else begin
          state_s = RESP;
        end
      end

      default: begin
        state_s       = IDLE;
        rb_addr_s     = '0;
        want_rb_s     = 1'b0;
        resp_tvalid_s = 1'b0;
        resp_tdata_s  = '0;
        resp_tuser_s  = ST_OK;
      end
    endcase

    cmd_tready_s = (state_s == IDLE);
    busy_s       = (state_s != IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cmd_tready_r  <= 1'b0;
      set_stb_r     <= 1'b0;
      set_addr_r    <= '0;
      set_data_r    <= '0;
      rb_addr_r     <= '0;
      want_rb_r     <= 1'b0;
      resp_tvalid_r <= 1'b0;
      resp_tdata_r  <= '0;
      resp_tuser_r  <= 2'b00;
      busy_r        <= 1'b0;
      timeout_cnt_r <= 16'd0;
    end else begin
      state_r       <= state_s;
      cmd_tready_r  <= cmd_tready_s;
      set_stb_r     <= set_stb_s;
      set_addr_r    <= set_addr_s;
      set_data_r    <= set_data_s;
      rb_addr_r     <= rb_addr_s;
      want_rb_r     <= want_rb_s;
      resp_tvalid_r <= resp_tvalid_s;
      resp_tdata_r  <= resp_tdata_s;
      resp_tuser_r  <= resp_tuser_s;
      busy_r        <= busy_s;
      timeout_cnt_r <= timeout_cnt_s;
    end
  end

  assign cmd_tready  = cmd_tready_r;
  assign set_stb     = set_stb_r;
  assign set_addr    = set_addr_r;
  assign set_data    = set_data_r;
  assign rb_addr     = rb_addr_r;
  assign resp_tvalid = resp_tvalid_r;
  assign resp_tdata  = resp_tdata_r;
  assign resp_tuser  = resp_tuser_r;
  assign busy        = busy_r;
  assign timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_settings_bus_cmd_bridge.sv
// Directed bench for settings_bus_cmd_bridge: a table of command vectors with
// hand-computed expectations, plus hand-written reset and stray-strobe sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_settings_bus_cmd_bridge;

  localparam int TIMEOUT = 16;
  localparam logic [63:0] RB_IDLE = 64'h5A5A_5A5A_5A5A_5A5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [63:0] resp_tdata;
  logic [1:0]  resp_tuser;
  logic        resp_tvalid;
  logic        resp_tready;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  rb_addr;
  logic        rb_stb;
  logic [63:0] rb_data;
  logic        busy;
  logic [15:0] timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  settings_bus_cmd_bridge #(
    .SR_AWIDTH (8),
    .SR_DWIDTH (32),
    .RB_AWIDTH (8),
    .RB_DWIDTH (64),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_tdata   (cmd_tdata),
    .cmd_tvalid  (cmd_tvalid),
    .cmd_tready  (cmd_tready),
    .resp_tdata  (resp_tdata),
    .resp_tuser  (resp_tuser),
    .resp_tvalid (resp_tvalid),
    .resp_tready (resp_tready),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .rb_addr     (rb_addr),
    .rb_stb      (rb_stb),
    .rb_data     (rb_data),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  typedef struct {
    string       name;
    logic [63:0] cmd;
    int          rb_delay;   // cycles after STROBE for the slave strobe; -1 = silent
    logic [63:0] rb_val;
    int          stall;      // cycles resp_tready stays low once resp_tvalid rises
    logic [7:0]  exp_saddr;
    logic [31:0] exp_sdata;
    logic [7:0]  exp_rbaddr;
    bit          exp_resp;
    logic [63:0] exp_tdata;
    logic [1:0]  exp_tuser;
    logic [15:0] exp_tocnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Runs one command starting at a falling edge with the bridge idle.
  task automatic run_vec(input vec_t v);
    int resp_cyc;
    int exp_cyc;
    chk({v.name, ".tready_idle"}, cmd_tready, 1);
    cmd_tdata  = v.cmd;
    cmd_tvalid = 1'b1;
    @(negedge clk);
    chk({v.name, ".set_stb"},  set_stb, 1);
    chk({v.name, ".set_addr"}, set_addr, v.exp_saddr);
    chk({v.name, ".set_data"}, set_data, v.exp_sdata);
    chk({v.name, ".rb_addr"},  rb_addr, v.exp_rbaddr);
    chk({v.name, ".tready_strobe"}, cmd_tready, 0);
    chk({v.name, ".busy_strobe"}, busy, 1);
    cmd_tvalid = 1'b0;
    cmd_tdata  = 64'd0;
    if (v.rb_delay == 0) begin
      rb_stb  = 1'b1;
      rb_data = v.rb_val;
    end
    if (!v.exp_resp) begin
      @(negedge clk);
      rb_stb  = 1'b0;
      rb_data = RB_IDLE;
      chk({v.name, ".set_stb_off"},  set_stb, 0);
      chk({v.name, ".set_addr_off"}, set_addr, 0);
      chk({v.name, ".set_data_off"}, set_data, 0);
      chk({v.name, ".tready_back"},  cmd_tready, 1);
      chk({v.name, ".busy_off"},     busy, 0);
      chk({v.name, ".no_resp"},      resp_tvalid, 0);
      chk({v.name, ".rb_addr_off"},  rb_addr, 0);
      chk({v.name, ".tocnt"},        timeout_cnt, v.exp_tocnt);
      return;
    end
    exp_cyc  = (v.rb_delay >= 0 && v.rb_delay <= TIMEOUT) ? 2 + v.rb_delay : 2 + TIMEOUT;
    resp_cyc = -1;
    for (int cyc = 2; cyc <= TIMEOUT + 8; cyc++) begin
      @(negedge clk);
      rb_stb  = 1'b0;
      rb_data = RB_IDLE;
      if (resp_tvalid) begin
        resp_cyc = cyc;
        break;
      end
      if (cyc == 2) begin
        chk({v.name, ".set_stb_off"}, set_stb, 0);
      end
      chk({v.name, ".rb_addr_held"}, rb_addr, v.exp_rbaddr);
      chk({v.name, ".tready_wait"},  cmd_tready, 0);
      if (cyc == 1 + v.rb_delay) begin
        rb_stb  = 1'b1;
        rb_data = v.rb_val;
      end
    end
    chk({v.name, ".resp_latency"}, resp_cyc, exp_cyc);
    if (resp_cyc < 0) begin
      return;
    end
    chk({v.name, ".tdata"},  resp_tdata, v.exp_tdata);
    chk({v.name, ".tuser"},  resp_tuser, v.exp_tuser);
    chk({v.name, ".tocnt"},  timeout_cnt, v.exp_tocnt);
    chk({v.name, ".tready_resp"}, cmd_tready, 0);
    chk({v.name, ".busy_resp"}, busy, 1);
    for (int s = 0; s < v.stall; s++) begin
      if (s == 0) begin
        rb_stb  = 1'b1;          // stray strobe while the response is held
        rb_data = ~v.rb_val;
      end
      @(negedge clk);
      rb_stb  = 1'b0;
      rb_data = RB_IDLE;
      chk({v.name, ".stall_tvalid"},  resp_tvalid, 1);
      chk({v.name, ".stall_tdata"},   resp_tdata, v.exp_tdata);
      chk({v.name, ".stall_tuser"},   resp_tuser, v.exp_tuser);
      chk({v.name, ".stall_tready"},  cmd_tready, 0);
      chk({v.name, ".stall_set_stb"}, set_stb, 0);
    end
    resp_tready = 1'b1;
    @(negedge clk);
    resp_tready = 1'b0;
    chk({v.name, ".resp_done"},   resp_tvalid, 0);
    chk({v.name, ".tready_back"}, cmd_tready, 1);
    chk({v.name, ".busy_off"},    busy, 0);
    chk({v.name, ".rb_addr_off"}, rb_addr, 0);
  endtask

  // Watchdog: a hung handshake must still end the run with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Field expectations come from the word layout: [31:0] data, [39:32] set_addr, [47:40] rb_addr, [48] want_rb.
    vecs[0] = '{"plain",     64'h0000_2A12_3456_789A, -1, 64'h0, 0, 8'h12, 32'h3456_789A, 8'h2A, 1'b0, 64'h0, 2'b00, 16'd0};
    vecs[1] = '{"rb_delay3", 64'h0001_0510_1122_3344,  3, 64'hDEAD_BEEF_CAFE_F00D, 0, 8'h10, 32'h1122_3344, 8'h05, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 16'd0};
    vecs[2] = '{"timeout1",  64'h0001_0720_0000_0001, -1, 64'h0, 0, 8'h20, 32'h0000_0001, 8'h07, 1'b1, 64'h0, 2'b01, 16'd1};
    vecs[3] = '{"same_cyc",  64'h0001_0930_A5A5_5A5A,  0, 64'h0123_4567_89AB_CDEF, 0, 8'h30, 32'hA5A5_5A5A, 8'h09, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b00, 16'd1};
    vecs[4] = '{"stall5",    64'h0001_0B40_FFFF_0000,  1, 64'h1111_2222_3333_4444, 5, 8'h40, 32'hFFFF_0000, 8'h0B, 1'b1, 64'h1111_2222_3333_4444, 2'b00, 16'd1};
    vecs[5] = '{"high_bits", 64'hFFFE_3CC3_0000_00FF, -1, 64'h0, 0, 8'hC3, 32'h0000_00FF, 8'h3C, 1'b0, 64'h0, 2'b00, 16'd1};
    vecs[6] = '{"last_cyc",  64'h0001_0E50_0000_0006, 16, 64'hAAAA_BBBB_CCCC_DDDD, 0, 8'h50, 32'h0000_0006, 8'h0E, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 16'd1};
    vecs[7] = '{"timeout2",  64'h0001_0F60_0000_0007, -1, 64'h0, 0, 8'h60, 32'h0000_0007, 8'h0F, 1'b1, 64'h0, 2'b01, 16'd2};
    vecs[8] = '{"post_rst",  64'h0001_1170_0000_0008,  2, 64'h0F0E_0D0C_0B0A_0908, 0, 8'h70, 32'h0000_0008, 8'h11, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 16'd0};

    reset_n     = 1'b0;
    cmd_tdata   = 64'd0;
    cmd_tvalid  = 1'b0;
    resp_tready = 1'b0;
    rb_stb      = 1'b0;
    rb_data     = RB_IDLE;
    repeat (3) @(negedge clk);
    chk("reset.cmd_tready",  cmd_tready, 0);
    chk("reset.busy",        busy, 0);
    chk("reset.resp_tvalid", resp_tvalid, 0);
    chk("reset.set_stb",     set_stb, 0);
    chk("reset.timeout_cnt", timeout_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 2) begin
        // Late strobe after the timeout response has been consumed.
        rb_stb  = 1'b1;
        rb_data = 64'hFEED_FACE_0000_0001;
        @(negedge clk);
        rb_stb  = 1'b0;
        rb_data = RB_IDLE;
        chk("late_rb.resp_tvalid", resp_tvalid, 0);
        chk("late_rb.busy",        busy, 0);
        chk("late_rb.set_stb",     set_stb, 0);
        chk("late_rb.cmd_tready",  cmd_tready, 1);
        chk("late_rb.timeout_cnt", timeout_cnt, 1);
      end
    end

    // Reset while waiting for a readback.
    cmd_tdata  = 64'h0001_0D50_0000_0077;
    cmd_tvalid = 1'b1;
    @(negedge clk);
    cmd_tvalid = 1'b0;
    cmd_tdata  = 64'd0;
    repeat (4) @(negedge clk);
    chk("mid_rst.busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst.cmd_tready",  cmd_tready, 0);
    chk("mid_rst.resp_tvalid", resp_tvalid, 0);
    chk("mid_rst.resp_tdata",  resp_tdata, 0);
    chk("mid_rst.resp_tuser",  resp_tuser, 0);
    chk("mid_rst.set_stb",     set_stb, 0);
    chk("mid_rst.set_addr",    set_addr, 0);
    chk("mid_rst.set_data",    set_data, 0);
    chk("mid_rst.rb_addr",     rb_addr, 0);
    chk("mid_rst.busy",        busy, 0);
    chk("mid_rst.timeout_cnt", timeout_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rb_stb  = 1'b1;
    rb_data = 64'hBEEF_0000_0000_0001;
    @(negedge clk);
    rb_stb  = 1'b0;
    rb_data = RB_IDLE;
    chk("after_rst.resp_tvalid", resp_tvalid, 0);
    chk("after_rst.busy",        busy, 0);
    chk("after_rst.cmd_tready",  cmd_tready, 1);
    repeat (2) @(negedge clk);
    chk("after_rst.no_resp", resp_tvalid, 0);
    run_vec(vecs[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
